// File: rtl/rx_frame_sequencer_pkg.sv
// Shared types and defaults for the UART receive frame sequencer.
package rx_frame_sequencer_pkg;

   localparam int RX_DATA_W = 8;
   localparam int RX_OVS    = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   typedef struct packed {
      logic parity_en;
      logic parity_odd;
      logic stop2;
   } rx_cfg_t;

   // Nonzero when data bits, received parity bit and odd-sense disagree.
   function automatic logic parity_calc(input logic [15:0] word, input logic line_bit,
                                        input logic odd);
      return (^word) ^ line_bit ^ odd;
   endfunction

endpackage

// File: rtl/rx_tick_cntr.sv
// Oversample tick counter with mid-bit (half) and end-of-bit (full) terminal compares.
module rx_tick_cntr
   import rx_frame_sequencer_pkg::*;
#(
   parameter int OVS = RX_OVS
) (
   input  logic clk,
   input  logic rst,
   input  logic enb,
   input  logic clear,
   input  logic load_zero,
   output logic half,
   output logic full
);

   localparam int CW = $clog2(OVS);
   localparam logic [CW-1:0] HALF_V = CW'(OVS / 2 - 1);
   localparam logic [CW-1:0] FULL_V = CW'(OVS - 1);

   logic [CW-1:0] count_r;

   // Tick count, advanced only on enb and wrapped at OVS-1.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_r <= '0;
      end else if (clear) begin
         count_r <= '0;
      end else if (enb) begin
         if (load_zero || (count_r == FULL_V)) begin
            count_r <= '0;
         end else begin
            count_r <= count_r + CW'(1);
         end
      end else begin
         count_r <= count_r;
      end
   end

   assign half = (count_r == HALF_V);
   assign full = (count_r == FULL_V);

endmodule

// File: rtl/rx_frame_sequencer.sv
// UART receive frame sequencer: start validation, mid-bit sampling, LSB-first
// assembly, optional parity and one or two stop bits.
module rx_frame_sequencer
   import rx_frame_sequencer_pkg::*;
#(
   parameter int DATA_W = RX_DATA_W,
   parameter int OVS    = RX_OVS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enb,
   input  logic              clear,
   input  logic              rxd,
   input  logic              parity_en,
   input  logic              parity_odd,
   input  logic              stop2,
   output logic [DATA_W-1:0] data,
   output logic              data_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int IDX_W = $clog2(DATA_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   rx_state_t         state_r, state_nx;
   logic [IDX_W-1:0]  bit_idx_r, bit_idx_nx;
   logic [DATA_W-1:0] shift_r, shift_nx;
   logic [DATA_W-1:0] data_r, data_nx;
   rx_cfg_t           cfg_r, cfg_nx;
   logic              stop_err_r, stop_err_nx;
   logic              stop_two_r, stop_two_nx;
   logic              par_hold_r, par_hold_nx;
   logic              dv_r, dv_nx, pe_r, pe_nx, fe_r, fe_nx, busy_r;
   logic              load_zero_s, half_s, full_s;

   rx_tick_cntr #(.OVS(OVS)) u_tick (
      .clk       (clk),
      .rst       (rst),
      .enb       (enb),
      .clear     (clear),
      .load_zero (load_zero_s),
      .half      (half_s),
      .full      (full_s)
   );

   // Next-state, datapath and strobe decode; nothing moves without enb.
   always_comb begin
      state_nx    = state_r;
      bit_idx_nx  = bit_idx_r;
      shift_nx    = shift_r;
      data_nx     = data_r;
      cfg_nx      = cfg_r;
      stop_err_nx = stop_err_r;
      stop_two_nx = stop_two_r;
      par_hold_nx = par_hold_r;
      dv_nx       = 1'b0;
      pe_nx       = 1'b0;
      fe_nx       = 1'b0;
      load_zero_s = 1'b0;
      if (enb) begin
         case (state_r)
            ST_IDLE: begin
               load_zero_s = 1'b1;
               if (!rxd) begin
                  state_nx          = ST_START;
                  cfg_nx.parity_en  = parity_en;
                  cfg_nx.parity_odd = parity_odd;
                  cfg_nx.stop2      = stop2;
               end else begin
                  state_nx = ST_IDLE;
               end
            end
            ST_START: begin
               if (half_s) begin
                  load_zero_s = 1'b1;
                  bit_idx_nx  = '0;
                  par_hold_nx = 1'b0;
                  state_nx    = rxd ? ST_IDLE : ST_DATA;
               end else begin
                  state_nx = ST_START;
               end
            end
            ST_DATA: begin
               if (full_s) begin
                  shift_nx = {rxd, shift_r[DATA_W-1:1]};
                  if (bit_idx_r == LAST_IDX) begin
                     bit_idx_nx  = '0;
                     stop_err_nx = 1'b0;
                     stop_two_nx = 1'b0;
                     state_nx    = cfg_r.parity_en ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_idx_nx = bit_idx_r + IDX_W'(1);
                  end
               end else begin
                  state_nx = ST_DATA;
               end
            end
            ST_PARITY: begin
               if (full_s) begin
                  par_hold_nx = parity_calc(16'(shift_r), rxd, cfg_r.parity_odd);
                  state_nx    = ST_STOP;
               end else begin
                  state_nx = ST_PARITY;
               end
            end
            ST_STOP: begin
               // First of two stop bits only records its error; the last one completes.
               if (full_s) begin
                  if (cfg_r.stop2 && !stop_two_r) begin
                     stop_err_nx = ~rxd;
                     stop_two_nx = 1'b1;
                  end else begin
                     fe_nx    = stop_err_r | ~rxd;
                     pe_nx    = par_hold_r & cfg_r.parity_en;
                     dv_nx    = 1'b1;
                     data_nx  = shift_r;
                     state_nx = ST_IDLE;
                  end
               end else begin
                  state_nx = ST_STOP;
               end
            end
            default: begin
               state_nx = ST_IDLE;
            end
         endcase
      end else begin
         state_nx = state_r;
      end
   end

   // State and output registers; clear aborts the frame but keeps the last word.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         bit_idx_r  <= '0;
         shift_r    <= '0;
         data_r     <= '0;
         cfg_r      <= '0;
         stop_err_r <= 1'b0;
         stop_two_r <= 1'b0;
         par_hold_r <= 1'b0;
         dv_r       <= 1'b0;
         pe_r       <= 1'b0;
         fe_r       <= 1'b0;
         busy_r     <= 1'b0;
      end else if (clear) begin
         state_r   <= ST_IDLE;
         bit_idx_r <= '0;
         dv_r      <= 1'b0;
         pe_r      <= 1'b0;
         fe_r      <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r    <= state_nx;
         bit_idx_r  <= bit_idx_nx;
         shift_r    <= shift_nx;
         data_r     <= data_nx;
         cfg_r      <= cfg_nx;
         stop_err_r <= stop_err_nx;
         stop_two_r <= stop_two_nx;
         par_hold_r <= par_hold_nx;
         dv_r       <= dv_nx;
         pe_r       <= pe_nx;
         fe_r       <= fe_nx;
         busy_r     <= (state_nx != ST_IDLE);
      end
   end

   assign data       = data_r;
   assign data_valid = dv_r;
   assign parity_err = pe_r;
   assign frame_err  = fe_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Directed bench for rx_frame_sequencer: 8-bit and 5-bit instances, OVS=16.
module tb_rx_frame_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic enb = 1'b0;
   logic clear = 1'b0;
   logic rxd = 1'b1;
   logic rxd5 = 1'b1;
   logic parity_en = 1'b0;
   logic parity_odd = 1'b0;
   logic stop2 = 1'b0;

   logic [7:0] data;
   logic       data_valid, parity_err, frame_err, busy;
   logic [4:0] data5;
   logic       dv5, pe5, fe5, busy5;

   int total = 0;
   int bad = 0;
   int enb_cnt = 0;
   int dv_cnt = 0;
   int dv_enb = 0;
   int dv5_cnt = 0;
   int base = 0;
   int d0 = 0;
   logic [7:0] cap_data = 8'h00;
   logic       cap_pe = 1'b0;
   logic       cap_fe = 1'b0;
   logic [4:0] cap_data5 = 5'h00;

   always #5 clk = ~clk;

   rx_frame_sequencer #(.DATA_W(8), .OVS(16)) u_dut (
      .clk(clk), .rst(rst), .enb(enb), .clear(clear), .rxd(rxd),
      .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
      .data(data), .data_valid(data_valid), .parity_err(parity_err),
      .frame_err(frame_err), .busy(busy)
   );

   rx_frame_sequencer #(.DATA_W(5), .OVS(16)) u_dut5 (
      .clk(clk), .rst(rst), .enb(enb), .clear(clear), .rxd(rxd5),
      .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
      .data(data5), .data_valid(dv5), .parity_err(pe5),
      .frame_err(fe5), .busy(busy5)
   );

   // Strobe monitor: every cycle data_valid is seen high counts as one word.
   always @(negedge clk) begin
      if (data_valid) begin
         dv_cnt   = dv_cnt + 1;
         dv_enb   = enb_cnt;
         cap_data = data;
         cap_pe   = parity_err;
         cap_fe   = frame_err;
      end
      if (dv5) begin
         dv5_cnt   = dv5_cnt + 1;
         cap_data5 = data5;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse();
      @(negedge clk);
      enb = 1'b1;
      enb_cnt = enb_cnt + 1;
      @(negedge clk);
      enb = 1'b0;
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      rxd5 = 1'b1;
      for (int i = 0; i < n; i++) pulse();
   endtask

   // Line bit k is held for 16 enb; only the first n_enb ticks are driven.
   task automatic send_line(input logic [15:0] line, input int n_enb, input logic to5);
      for (int i = 0; i < n_enb; i++) begin
         if (to5) begin
            rxd5 = line[i / 16];
            rxd  = 1'b1;
         end else begin
            rxd  = line[i / 16];
            rxd5 = 1'b1;
         end
         pulse();
      end
      rxd = 1'b1;
      rxd5 = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_data", data, 8'h00);
      chk("rst_dv", data_valid, 1'b0);
      chk("rst_pe", parity_err, 1'b0);
      chk("rst_fe", frame_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_busy", busy, 1'b0);

      // 8N1 0x55, strobe timing relative to the detection enb
      base = enb_cnt;
      send_line({6'b0, 1'b1, 8'h55, 1'b0}, 160, 1'b0);
      chk("n1_dv_count", dv_cnt, 1);
      chk("n1_dv_enb", dv_enb, base + 153);
      chk("n1_data", cap_data, 8'h55);
      chk("n1_pe", cap_pe, 1'b0);
      chk("n1_fe", cap_fe, 1'b0);
      chk("n1_busy_end", busy, 1'b0);
      chk("n1_data_hold", data, 8'h55);

      // false start glitch
      d0 = dv_cnt;
      rxd = 1'b0;
      pulse();
      chk("glitch_busy_rise", busy, 1'b1);
      repeat (3) pulse();
      rxd = 1'b1;
      repeat (4) pulse();
      chk("glitch_busy_7", busy, 1'b1);
      pulse();
      chk("glitch_busy_8", busy, 1'b0);
      idle(16);
      chk("glitch_no_dv", dv_cnt, d0);

      // 8E1 with wrong parity, then 8O1 with the same bit
      parity_en = 1'b1;
      parity_odd = 1'b0;
      send_line({5'b0, 1'b1, 1'b1, 8'hA3, 1'b0}, 176, 1'b0);
      chk("e1_dv_count", dv_cnt, d0 + 1);
      chk("e1_data", cap_data, 8'hA3);
      chk("e1_pe", cap_pe, 1'b1);
      chk("e1_fe", cap_fe, 1'b0);
      parity_odd = 1'b1;
      send_line({5'b0, 1'b1, 1'b1, 8'hA3, 1'b0}, 176, 1'b0);
      chk("o1_dv_count", dv_cnt, d0 + 2);
      chk("o1_pe", cap_pe, 1'b0);
      chk("o1_data", cap_data, 8'hA3);
      parity_en = 1'b0;
      parity_odd = 1'b0;

      // 8N2, second stop low, then a clean 8N2 frame
      stop2 = 1'b1;
      send_line({5'b0, 1'b0, 1'b1, 8'h69, 1'b0}, 169, 1'b0);
      idle(8);
      chk("n2_err_dv_count", dv_cnt, d0 + 3);
      chk("n2_err_data", cap_data, 8'h69);
      chk("n2_err_fe", cap_fe, 1'b1);
      chk("n2_err_pe", cap_pe, 1'b0);
      send_line({5'b0, 1'b1, 1'b1, 8'h96, 1'b0}, 176, 1'b0);
      chk("n2_ok_dv_count", dv_cnt, d0 + 4);
      chk("n2_ok_data", cap_data, 8'h96);
      chk("n2_ok_fe", cap_fe, 1'b0);
      stop2 = 1'b0;

      // clear mid-frame at enb 60, then 0x3C
      d0 = dv_cnt;
      send_line({6'b0, 1'b1, 8'hC7, 1'b0}, 60, 1'b0);
      chk("clr_busy_before", busy, 1'b1);
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clr_busy_after", busy, 1'b0);
      idle(20);
      chk("clr_no_dv", dv_cnt, d0);
      chk("clr_data_kept", data, 8'h96);
      send_line({6'b0, 1'b1, 8'h3C, 1'b0}, 160, 1'b0);
      chk("post_clr_dv", dv_cnt, d0 + 1);
      chk("post_clr_data", cap_data, 8'h3C);

      // clear coinciding with the completing enb
      d0 = dv_cnt;
      send_line({6'b0, 1'b1, 8'h5A, 1'b0}, 152, 1'b0);
      @(negedge clk);
      enb = 1'b1;
      clear = 1'b1;
      enb_cnt = enb_cnt + 1;
      @(negedge clk);
      enb = 1'b0;
      clear = 1'b0;
      chk("clr_win_dv", data_valid, 1'b0);
      chk("clr_win_busy", busy, 1'b0);
      idle(8);
      chk("clr_win_count", dv_cnt, d0);
      chk("clr_win_data", data, 8'h3C);

      // back-to-back 0x00 then 0xFF
      d0 = dv_cnt;
      send_line({6'b0, 1'b1, 8'h00, 1'b0}, 160, 1'b0);
      chk("b2b_first_dv", dv_cnt, d0 + 1);
      chk("b2b_first_data", cap_data, 8'h00);
      send_line({6'b0, 1'b1, 8'hFF, 1'b0}, 160, 1'b0);
      chk("b2b_second_dv", dv_cnt, d0 + 2);
      chk("b2b_second_data", cap_data, 8'hFF);
      chk("b2b_second_fe", cap_fe, 1'b0);

      // DATA_W=5 instance, word 0x15
      chk("w5_quiet", dv5_cnt, 0);
      d0 = dv_cnt;
      send_line({9'b0, 1'b1, 5'h15, 1'b0}, 112, 1'b1);
      chk("w5_dv_count", dv5_cnt, 1);
      chk("w5_data", cap_data5, 5'h15);
      chk("w5_fe", fe5, 1'b0);
      chk("w5_busy", busy5, 1'b0);
      chk("w5_other_quiet", dv_cnt, d0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rx_frame_sequencer.md
# rx_frame_sequencer

Parametrised UART receive frame sequencer. It oversamples the serial line on an external tick, rejects false start bits, and samples each bit at mid-bit. It assembles DATA_W data bits LSB first, handles optional parity and one or two stop bits, and reports the received word with error flags. It sits between the baud/oversample tick generator and the RX data register, and replaces the fixed-length received-bit counter and overflow comparator.

## Interface
- DATA_W, 8, data bits per frame; legal range 5..9
- OVS, 16, oversample ticks per bit; even, >= 4
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- enb  in  1  oversample tick; one-cycle pulse, OVS per bit time
- clear  in  1  synchronous abort to IDLE
- rxd  in  1  serial line, already synchronised; idle high
- parity_en  in  1  parity bit present
- parity_odd  in  1  1 = odd parity, 0 = even parity
- stop2  in  1  two stop bits
- data  out  DATA_W  received word; holds its value until the next frame completes
- data_valid  out  1  one-cycle strobe, word complete
- parity_err  out  1  qualified by data_valid
- frame_err  out  1  a stop bit sampled low; qualified by data_valid
- busy  out  1  state != IDLE

## Operation
- Priority: rst low > clear > enb > hold. With enb low, all state holds.
- Reset and clear values: state IDLE, tick counter 0, bit index 0, data 0, data_valid 0, parity_err 0, frame_err 0, busy 0. clear does not modify data.
- Configuration (parity_en, parity_odd, stop2) is latched on start detection. Changes mid-frame have no effect until the next frame.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on enb with rxd=0, go to START, tick counter 0, latch configuration.
  - START: count enb. On the enb where tick counter = OVS/2-1, sample rxd.
    - rxd=1: false start; return to IDLE with no strobe.
    - rxd=0: go to DATA, tick counter 0, bit index 0.
  - DATA: on the enb where tick counter = OVS-1, sample, tick counter 0.
    - Shift rxd in at the MSB of the shift register (LSB-first line order).
    - At bit index = DATA_W-1, go to PARITY if parity_en, else STOP. Otherwise increment bit index.
  - PARITY: sample at OVS-1. parity_err = (XOR of data bits XOR sampled bit XOR parity_odd) != 0. Go to STOP.
  - STOP: sample at OVS-1.
    - If stop2 and this is the first stop bit, record its error and stay in STOP for the second.
    - On the final stop sample: frame_err = OR of all stop samples that were low; copy the shift register to data; pulse data_valid; go to IDLE.
- Returning to IDLE at mid-stop-bit allows a start edge in the very next bit time.
- A frame_err frame still produces data_valid, with frame_err=1.
- When parity_en=0, parity_err = 0.
- The tick counter is $clog2(OVS) bits wide and never exceeds OVS-1. The bit index is $clog2(DATA_W) bits wide and never exceeds DATA_W-1. Neither counter wraps outside these bounds.

## Timing
- The sample for line bit n (start = 0) is taken on the OVS/2 + n·OVS-th enb after the detection enb.
- 8N1 with OVS=16: the final stop bit is sampled on the 152nd enb after detection. data_valid is high in the clk cycle after that enb.
- data_valid, parity_err and frame_err are registered: high for exactly one clk, one cycle after the sampling enb.
- busy rises the cycle after detection and falls in the same cycle data_valid rises.
- clear or rst asserted mid-frame: IDLE on the next edge, with no data_valid for the aborted frame.
- clear asserted in the same cycle as a completing enb: clear wins, with no strobe.

## Structure
- Definitions_Package gets:
  - rx_state_t, a 3-bit enum
  - rx_cfg_t, a struct {parity_en, parity_odd, stop2}
  - default constants RX_DATA_W=8 and RX_OVS=16
- One sub-module, rx_tick_cntr: parametrised OVS counter with enb, clear, load-zero, and terminal-compare outputs (half, full). It is instantiated once. The FSM, shift register and error logic stay in the top module.

## Test plan
- 8N1, OVS=16, byte 0x55, reset released → data=0x55, data_valid high exactly one cycle, 1 cycle after enb #152, both errors 0.
- Glitch: rxd low for 4 enb then high → no data_valid, busy falls after enb #8, state IDLE.
- 8E1 send 0xA3 with parity bit 1 (wrong) → data=0xA3, parity_err=1. 8O1 send 0xA3 with parity bit 1 → parity_err=0.
- 8N2, second stop bit driven low → data_valid with frame_err=1. The next frame, with both stop bits high, gives frame_err=0.
- clear pulsed at enb #60 of a frame → busy=0 next cycle, no data_valid, data keeps its previous value. The following frame 0x3C is received correctly.
- Back-to-back 8N1 frames 0x00 then 0xFF, with a start edge immediately after the stop bit → two data_valid strobes, data 0x00 then 0xFF. Also repeat with DATA_W=5: word 0x15 is received.
